register_rename: RTL

//  In-order rename stage, directly upstream of the issue table. Takes one decoded

---
 rtl/register_rename_pkg.sv | 48 ++++
 rtl/register_rename_priority_encoder.sv | 24 ++
 rtl/register_rename.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/register_rename_pkg.sv
// Shared types and sizing for the rename stage: decoded/renamed instruction
// records, register-id widths and the post-reset free list.
package register_rename_pkg;

    localparam int NUM_ARCH_REG = 8;
    localparam int NUM_PHYS_REG = 32;
    localparam int WORD_SIZE_P  = 16;
    localparam int AR_W         = $clog2(NUM_ARCH_REG);
    localparam int PR_W         = $clog2(NUM_PHYS_REG);

    typedef logic [AR_W-1:0] arch_id_t;
    typedef logic [PR_W-1:0] phys_id_t;

    // Architectural regs start mapped 1:1, so only the pregs above them are free.
    localparam logic [NUM_PHYS_REG-1:0] RESET_FREE_VEC =
        {{(NUM_PHYS_REG-NUM_ARCH_REG){1'b1}}, {NUM_ARCH_REG{1'b0}}};

    typedef struct packed {
        logic [WORD_SIZE_P-1:0] pc;
        logic [5:0]             opcode;
        logic [2:0]             fu;
        arch_id_t               src1;
        arch_id_t               src2;
        arch_id_t               dest;
        logic                   imm;
        logic [WORD_SIZE_P-1:0] source2_imm;
        logic                   w_v;
        logic [3:0]             flags;
        logic                   sb_dest;
        logic                   is_wfs;
    } decoded_instruction_t;

    typedef struct packed {
        logic [WORD_SIZE_P-1:0] pc;
        logic [5:0]             opcode;
        logic [2:0]             fu;
        phys_id_t               source_1;
        logic [WORD_SIZE_P-1:0] source2_imm;
        logic                   imm;
        phys_id_t               dest_id;
        phys_id_t               prev_dest_id;
        logic                   w_v;
        logic [3:0]             flags;
        logic                   sb_dest;
        logic                   is_wfs;
    } renamed_instruction_t;

endpackage

// File: rtl/register_rename_priority_encoder.sv
// Lowest-index-wins priority encoder; picks the next physical register from
// the free bit-vector.
module priority_encoder #(
    parameter int els_p = 32,
    localparam int W    = $clog2(els_p)
) (
    input  logic [els_p-1:0] requests,
    output logic [W-1:0]     index,
    output logic             found
);

    // Scan from the top so the last hit written is the lowest set bit.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (requests[i]) begin
                index = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_rename.sv
// In-order rename stage: maps architectural operands through a speculative RAT,
// allocates destinations from a free bit-vector and recovers from the retirement RAT.
module register_rename
    import register_rename_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  decoded_instruction_t instruction_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output renamed_instruction_t instruction_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic                 commit_v_i,
    input  arch_id_t             commit_arch_i,
    input  phys_id_t             commit_preg_i,
    input  phys_id_t             commit_prev_preg_i,
    input  logic                 flush_i
);

    phys_id_t spec_rat     [NUM_ARCH_REG];
    phys_id_t ret_rat      [NUM_ARCH_REG];
    phys_id_t ret_rat_next [NUM_ARCH_REG];

    logic [NUM_PHYS_REG-1:0] free_vec;
    logic [NUM_PHYS_REG-1:0] free_vec_next;
    logic [NUM_PHYS_REG-1:0] flush_free_vec;

    phys_id_t             alloc_preg;
    logic                 any_free;
    logic                 accept;
    logic                 alloc;
    renamed_instruction_t renamed;

    priority_encoder #(.els_p(NUM_PHYS_REG)) free_pick (
        .requests (free_vec),
        .index    (alloc_preg),
        .found    (any_free)
    );

    // Stalls whenever the free list is empty, even for non-writing instructions.
    assign ready_o = ~reset_i & ~flush_i & (~valid_o | ready_i) & any_free;
    assign accept  = valid_i & ready_o;
    assign alloc   = accept & instruction_i.w_v;

    always_comb begin
        for (int i = 0; i < NUM_ARCH_REG; i++) begin
            ret_rat_next[i] = ret_rat[i];
        end
        if (commit_v_i) begin
            ret_rat_next[commit_arch_i] = commit_preg_i;
        end
    end

    // On recovery, every preg not named by the committed map is free again.
    always_comb begin
        flush_free_vec = '1;
        for (int i = 0; i < NUM_ARCH_REG; i++) begin
            flush_free_vec[ret_rat_next[i]] = 1'b0;
        end
    end

    always_comb begin
        free_vec_next = free_vec;
        if (alloc) begin
            free_vec_next[alloc_preg] = 1'b0;
        end
        if (commit_v_i) begin
            free_vec_next[commit_prev_preg_i] = 1'b1;
        end
    end

    // Operands read the RAT before this edge's write, so src == dest sees the old mapping.
    always_comb begin
        renamed              = '0;
        renamed.pc           = instruction_i.pc;
        renamed.opcode       = instruction_i.opcode;
        renamed.fu           = instruction_i.fu;
        renamed.imm          = instruction_i.imm;
        renamed.w_v          = instruction_i.w_v;
        renamed.flags        = instruction_i.flags;
        renamed.sb_dest      = instruction_i.sb_dest;
        renamed.is_wfs       = instruction_i.is_wfs;
        renamed.source_1     = spec_rat[instruction_i.src1];
        renamed.source2_imm  = instruction_i.imm ? instruction_i.source2_imm
                                                 : WORD_SIZE_P'(spec_rat[instruction_i.src2]);
        renamed.dest_id      = instruction_i.w_v ? alloc_preg : '0;
        renamed.prev_dest_id = spec_rat[instruction_i.dest];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                spec_rat[i] <= PR_W'(i);
                ret_rat[i]  <= PR_W'(i);
            end
            free_vec <= RESET_FREE_VEC;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                spec_rat[i] <= ret_rat_next[i];
                ret_rat[i]  <= ret_rat_next[i];
            end
            free_vec <= flush_free_vec;
        end else begin
            if (alloc) begin
                spec_rat[instruction_i.dest] <= alloc_preg;
            end
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                ret_rat[i] <= ret_rat_next[i];
            end
            free_vec <= free_vec_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o       <= 1'b0;
            instruction_o <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (accept) begin
            instruction_o <= renamed;
            valid_o       <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // A retiring preg must still be in use, and an allocation must never hand out a busy one.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (commit_v_i) begin
                assert (!free_vec[commit_prev_preg_i]);
            end
            if (alloc) begin
                assert (free_vec[alloc_preg] && !(commit_v_i && commit_prev_preg_i == alloc_preg));
            end
        end
    end

endmodule
